// File: rtl/t07_lcd_frame_writer_pkg.sv
// Shared types and constants for the LCD frame writer.
// Provides the FSM state enum, command opcodes, default colours, header lookup.
package t07_lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PIX_W0,
    PIX_W1,
    PIX_HI,
    PIX_LO,
    DONE
  } state_t;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam logic [15:0] DEF_BG     = 16'hFFFF;
  localparam logic [15:0] DEF_FLOOR  = 16'h8410;
  localparam logic [15:0] DEF_CACTUS = 16'h03E0;
  localparam logic [15:0] DEF_DINO   = 16'hF800;

  localparam int HDR_LEN = 11;

  // Returns {dcx, byte} for header position idx.
  function automatic logic [8:0] hdr_byte(
    input logic [3:0]  idx,
    input logic [15:0] x_end,
    input logic [15:0] y_end
  );
    logic [8:0] w;
    case (idx)
      4'd0:    w = {1'b0, CMD_CASET};
      4'd1:    w = {1'b1, 8'h00};
      4'd2:    w = {1'b1, 8'h00};
      4'd3:    w = {1'b1, x_end[15:8]};
      4'd4:    w = {1'b1, x_end[7:0]};
      4'd5:    w = {1'b0, CMD_PASET};
      4'd6:    w = {1'b1, 8'h00};
      4'd7:    w = {1'b1, 8'h00};
      4'd8:    w = {1'b1, y_end[15:8]};
      4'd9:    w = {1'b1, y_end[7:0]};
      4'd10:   w = {1'b0, CMD_RAMWR};
      default: w = {1'b1, 8'h00};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/t07_lcd_frame_writer_if.sv
// 8080 write-only LCD bus: data, dcx (0=cmd), wrx and csx (active low).
// master drives the pins, slave observes them.
interface t07_lcd_frame_writer_if;
  logic [7:0] lcd_data;
  logic       lcd_dcx;
  logic       lcd_wrx;
  logic       lcd_csx;

  modport master (
    output lcd_data,
    output lcd_dcx,
    output lcd_wrx,
    output lcd_csx
  );

  modport slave (
    input lcd_data,
    input lcd_dcx,
    input lcd_wrx,
    input lcd_csx
  );
endinterface

// File: rtl/t07_lcd_frame_writer_byte_tx.sv
// Single-byte 8080 write: wrx low WR_CYCLES, then high WR_CYCLES.
// In: tx_byte/tx_dcx/valid. Out: data/dcx/wrx, done (last high cycle).
module t07_lcd_byte_tx #(
  parameter int WR_CYCLES = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       valid,
  input  logic [7:0] tx_byte,
  input  logic       tx_dcx,
  output logic [7:0] data,
  output logic       dcx,
  output logic       wrx,
  output logic       done
);

  localparam int CW = $clog2(WR_CYCLES + 1);

  logic          active;
  logic          hi_ph;
  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(WR_CYCLES - 1));
  // done is combinational so a new byte can load on the same edge.
  assign done = active & hi_ph & last;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      active <= 1'b0;
      hi_ph  <= 1'b0;
      cnt    <= '0;
      data   <= 8'h00;
      dcx    <= 1'b1;
      wrx    <= 1'b1;
    end else if (valid && (!active || done)) begin
      active <= 1'b1;
      hi_ph  <= 1'b0;
      cnt    <= '0;
      data   <= tx_byte;
      dcx    <= tx_dcx;
      wrx    <= 1'b0;
    end else if (active) begin
      if (last) begin
        cnt <= '0;
        if (hi_ph) begin
          active <= 1'b0;
        end else begin
          hi_ph <= 1'b1;
          wrx   <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/t07_lcd_frame_writer.sv
// Scans H_RES x V_RES, maps generator flags to RGB565, streams one frame.
// Ports: clk/nrst/start, r_* flags, x/y to generator, lcd bus, busy/frame_done.
module t07_lcd_frame_writer
  import t07_lcd_pkg::*;
#(
  parameter int          H_RES        = 320,
  parameter int          V_RES        = 240,
  parameter int          WR_CYCLES    = 1,
  parameter logic [15:0] COLOR_BG     = DEF_BG,
  parameter logic [15:0] COLOR_FLOOR  = DEF_FLOOR,
  parameter logic [15:0] COLOR_CACTUS = DEF_CACTUS,
  parameter logic [15:0] COLOR_DINO   = DEF_DINO
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  input  logic                    r_floor,
  input  logic                    r_dino,
  input  logic                    r_cactus,
  output logic [8:0]              x,
  output logic [7:0]              y,
  t07_lcd_frame_writer_if.master  lcd,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int          NPIX  = H_RES * V_RES;
  localparam int          PW    = $clog2(NPIX + 1);
  localparam logic [15:0] X_END = 16'(H_RES - 1);
  localparam logic [15:0] Y_END = 16'(V_RES - 1);

  state_t        state;
  state_t        state_n;
  logic [3:0]    hdr_idx;
  logic [PW-1:0] pix_cnt;
  logic          last_pix;
  logic [15:0]   colour;
  logic [15:0]   colour_q;
  logic          tx_valid;
  logic [8:0]    tx_word;
  logic          tx_done;
  logic          csx;
  logic [7:0]    tx_data;
  logic          tx_dcx_o;
  logic          tx_wrx;

  t07_lcd_byte_tx #(
    .WR_CYCLES (WR_CYCLES)
  ) u_tx (
    .clk     (clk),
    .nrst    (nrst),
    .valid   (tx_valid),
    .tx_byte (tx_word[7:0]),
    .tx_dcx  (tx_word[8]),
    .data    (tx_data),
    .dcx     (tx_dcx_o),
    .wrx     (tx_wrx),
    .done    (tx_done)
  );

  assign lcd.lcd_data = tx_data;
  assign lcd.lcd_dcx  = tx_dcx_o;
  assign lcd.lcd_wrx  = tx_wrx;
  assign lcd.lcd_csx  = csx;

  assign last_pix = (pix_cnt == PW'(NPIX - 1));

  always_comb begin
    colour = COLOR_BG;
    priority case (1'b1)
      r_dino:   colour = COLOR_DINO;
      r_cactus: colour = COLOR_CACTUS;
      r_floor:  colour = COLOR_FLOOR;
      default:  colour = COLOR_BG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = HDR;
      HDR:     if (tx_done && hdr_idx == 4'(HDR_LEN))
                 state_n = PIX_W0;
      PIX_W0:  state_n = PIX_W1;
      PIX_W1:  state_n = PIX_HI;
      PIX_HI:  if (tx_done) state_n = PIX_LO;
      PIX_LO:  if (tx_done)
                 state_n = last_pix ? DONE : PIX_W0;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx_valid   = 1'b0;
    tx_word    = {1'b1, 8'h00};
    busy       = 1'b1;
    csx        = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        csx  = 1'b1;
        if (start) begin
          tx_valid = 1'b1;
          tx_word  = hdr_byte(4'd0, X_END, Y_END);
        end
      end
      HDR: begin
        if (tx_done && hdr_idx != 4'(HDR_LEN)) begin
          tx_valid = 1'b1;
          tx_word  = hdr_byte(hdr_idx, X_END, Y_END);
        end
      end
      PIX_W1: begin
        tx_valid = 1'b1;
        tx_word  = {1'b1, colour[15:8]};
      end
      PIX_HI: begin
        if (tx_done) begin
          tx_valid = 1'b1;
          tx_word  = {1'b1, colour_q[7:0]};
        end
      end
      DONE: begin
        busy       = 1'b0;
        csx        = 1'b1;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      hdr_idx  <= 4'd0;
      pix_cnt  <= '0;
      x        <= 9'd0;
      y        <= 8'd0;
      colour_q <= COLOR_BG;
    end else begin
      if (state == IDLE && start)
        hdr_idx <= 4'd1;
      else if (state == HDR && tx_valid)
        hdr_idx <= hdr_idx + 4'd1;
      if (state == PIX_W1)
        colour_q <= colour;
      if (state == PIX_LO && tx_done) begin
        if (last_pix) begin
          pix_cnt <= '0;
          x       <= 9'd0;
          y       <= 8'd0;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
          if (x == 9'(H_RES - 1)) begin
            x <= 9'd0;
            if (y != 8'(V_RES - 1)) y <= y + 8'd1;
          end else begin
            x <= x + 9'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_t07_lcd_frame_writer.sv
// Randomised bench for t07_lcd_frame_writer against a byte-stream model.
// Three instances: full 320x240 header/reset, 4x2 WR=1, 3x2 WR=3.
module tb_t07_lcd_frame_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst_a, nrst_bc;
  logic start_a, start_b, start_c;

  logic [8:0] x_a, x_b, x_c;
  logic [7:0] y_a, y_b, y_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic [2:0] fl_b, fl_c;
  logic [2:0] tbl_b [8];
  logic [2:0] tbl_c [6];

  t07_lcd_frame_writer_if if_a ();
  t07_lcd_frame_writer_if if_b ();
  t07_lcd_frame_writer_if if_c ();

  t07_lcd_frame_writer u_a (
    .clk(clk), .nrst(nrst_a), .start(start_a),
    .r_floor(1'b0), .r_dino(1'b0), .r_cactus(1'b0),
    .x(x_a), .y(y_a), .lcd(if_a),
    .busy(busy_a), .frame_done(done_a)
  );

  t07_lcd_frame_writer #(
    .H_RES(4), .V_RES(2), .WR_CYCLES(1)
  ) u_b (
    .clk(clk), .nrst(nrst_bc), .start(start_b),
    .r_floor(fl_b[0]), .r_dino(fl_b[2]), .r_cactus(fl_b[1]),
    .x(x_b), .y(y_b), .lcd(if_b),
    .busy(busy_b), .frame_done(done_b)
  );

  t07_lcd_frame_writer #(
    .H_RES(3), .V_RES(2), .WR_CYCLES(3)
  ) u_c (
    .clk(clk), .nrst(nrst_bc), .start(start_c),
    .r_floor(fl_c[0]), .r_dino(fl_c[2]), .r_cactus(fl_c[1]),
    .x(x_c), .y(y_c), .lcd(if_c),
    .busy(busy_c), .frame_done(done_c)
  );

  // Pixel generator: flags registered one clock after x/y.
  always @(posedge clk) begin
    fl_b <= (x_b < 4 && y_b < 2) ? tbl_b[y_b * 4 + x_b] : 3'b000;
    fl_c <= (x_c < 3 && y_c < 2) ? tbl_c[y_c * 3 + x_c] : 3'b000;
  end

  int sel = 0;
  logic [7:0] o_data;
  logic o_dcx, o_wrx, o_csx, o_busy, o_done;
  logic [8:0] o_x;
  logic [7:0] o_y;

  always_comb begin
    if (sel == 0) begin
      o_data = if_b.lcd_data; o_dcx = if_b.lcd_dcx;
      o_wrx = if_b.lcd_wrx; o_csx = if_b.lcd_csx;
      o_busy = busy_b; o_done = done_b; o_x = x_b; o_y = y_b;
    end else begin
      o_data = if_c.lcd_data; o_dcx = if_c.lcd_dcx;
      o_wrx = if_c.lcd_wrx; o_csx = if_c.lcd_csx;
      o_busy = busy_c; o_done = done_c; o_x = x_c; o_y = y_c;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] hdr_model(int i, int h, int v);
    logic [15:0] xe;
    logic [15:0] ye;
    logic [8:0] t [11];
    xe = 16'(h - 1);
    ye = 16'(v - 1);
    t = '{{1'b0, 8'h2A}, 9'h100, 9'h100, {1'b1, xe[15:8]},
          {1'b1, xe[7:0]}, {1'b0, 8'h2B}, 9'h100, 9'h100,
          {1'b1, ye[15:8]}, {1'b1, ye[7:0]}, {1'b0, 8'h2C}};
    return t[i];
  endfunction

  // f = {dino, cactus, floor}
  function automatic logic [15:0] col_model(logic [2:0] f);
    if (f[2]) return 16'hF800;
    if (f[1]) return 16'h03E0;
    if (f[0]) return 16'h8410;
    return 16'hFFFF;
  endfunction

  task automatic chk_rst(input string tag, input logic [7:0] d,
                         input logic dcx, input logic wrx,
                         input logic csx, input logic bsy,
                         input logic fd, input logic [8:0] xx,
                         input logic [7:0] yy);
    check({tag, "_data"}, d, 8'h00);
    check({tag, "_dcx"}, dcx, 1'b1);
    check({tag, "_wrx"}, wrx, 1'b1);
    check({tag, "_csx"}, csx, 1'b1);
    check({tag, "_busy"}, bsy, 1'b0);
    check({tag, "_done"}, fd, 1'b0);
    check({tag, "_x"}, xx, 9'd0);
    check({tag, "_y"}, yy, 8'd0);
  endtask

  task automatic run_frame(input int s, input logic [2:0] p0);
    int h, v, wr, np, exp_done, rel, done_rel, ndone;
    int low_run, bad_low, bad_xy, bad_fall, post_busy;
    logic prev_wrx;
    logic [15:0] c;
    logic [2:0] f;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int exp_fall[$];
    int got_fall[$];
    logic [16:0] xy_q[$];
    string tg;
    sel = s;
    h = (s == 0) ? 4 : 3;
    v = 2;
    wr = (s == 0) ? 1 : 3;
    np = h * v;
    tg = $sformatf("f%0d_%0h", s, p0);
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(hdr_model(i, h, v));
      exp_fall.push_back(1 + 2 * wr * i);
    end
    for (int p = 0; p < np; p++) begin
      f = (p == 0) ? p0 : 3'($urandom_range(0, 7));
      if (s == 0) tbl_b[p] = f;
      else tbl_c[p] = f;
      c = col_model(f);
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
      exp_fall.push_back(1 + 22 * wr + p * (2 + 4 * wr) + 2);
      exp_fall.push_back(1 + 22 * wr + p * (2 + 4 * wr) + 2 + 2 * wr);
    end
    exp_done = 1 + 22 * wr + np * (2 + 4 * wr);
    done_rel = -1; ndone = 0; low_run = 0; bad_low = 0;
    bad_xy = 0; post_busy = 0; prev_wrx = 1'b1;
    @(negedge clk);
    if (s == 0) start_b = 1'b1; else start_c = 1'b1;
    @(negedge clk);
    start_b = 1'b0; start_c = 1'b0;
    rel = 1;
    while (rel <= exp_done + 20) begin
      if (rel == 1) begin
        check({tg, "_busy1"}, o_busy, 1'b1);
        check({tg, "_csx1"}, o_csx, 1'b0);
      end
      if (!o_wrx && prev_wrx) got_fall.push_back(rel);
      if (o_wrx && !prev_wrx) begin
        got_q.push_back({o_dcx, o_data});
        if (got_q.size() > 11 && (got_q.size() % 2) == 0)
          xy_q.push_back({o_y, o_x});
        if (low_run != wr) bad_low++;
        low_run = 0;
      end
      if (!o_wrx) low_run++;
      if (o_busy && (o_x >= 9'(h) || o_y >= 8'(v))) bad_xy++;
      if (done_rel > 0 && rel > done_rel && o_busy) post_busy++;
      if (o_done) begin
        ndone++;
        if (ndone == 1) begin
          done_rel = rel;
          check({tg, "_done_busy"}, o_busy, 1'b0);
          check({tg, "_done_csx"}, o_csx, 1'b1);
          check({tg, "_done_xy"}, {o_y, o_x}, 17'd0);
        end
      end
      start_b = 1'b0; start_c = 1'b0;
      if (rel == 5 || rel == exp_done) begin
        if (s == 0) start_b = 1'b1; else start_c = 1'b1;
      end
      prev_wrx = o_wrx;
      @(negedge clk);
      rel++;
    end
    start_b = 1'b0; start_c = 1'b0;
    check({tg, "_ndone"}, ndone, 1);
    check({tg, "_done_rel"}, done_rel, exp_done);
    check({tg, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tg, i), got_q[i], exp_q[i]);
    bad_fall = (got_fall.size() == exp_fall.size()) ? 0 : 1;
    for (int i = 0; i < exp_fall.size() && i < got_fall.size(); i++)
      if (got_fall[i] != exp_fall[i]) bad_fall++;
    check({tg, "_fall_times"}, bad_fall, 0);
    check({tg, "_low_len"}, bad_low, 0);
    check({tg, "_xy_range"}, bad_xy, 0);
    check({tg, "_post_busy"}, post_busy, 0);
    check({tg, "_nxy"}, xy_q.size(), np);
    for (int p = 0; p < np && p < xy_q.size(); p++)
      check($sformatf("%s_xy%0d", tg, p), xy_q[p],
            {8'(p / h), 9'(p % h)});
  endtask

  task automatic grab_hdr_a(input string tg);
    logic [8:0] got[$];
    logic [8:0] exp [11];
    logic prev;
    int n;
    exp = '{9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F, 9'h02B,
            9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C};
    prev = 1'b1;
    n = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (got.size() < 11 && n < 100) begin
      if (if_a.lcd_wrx && !prev) got.push_back({if_a.lcd_dcx, if_a.lcd_data});
      prev = if_a.lcd_wrx;
      @(negedge clk);
      n++;
    end
    check({tg, "_nhdr"}, got.size(), 11);
    for (int i = 0; i < 11 && i < got.size(); i++)
      check($sformatf("%s_hdr%0d", tg, i), got[i], exp[i]);
  endtask

  initial begin
    int n;
    nrst_a = 1'b0; nrst_bc = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    for (int i = 0; i < 8; i++) tbl_b[i] = 3'b000;
    for (int i = 0; i < 6; i++) tbl_c[i] = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("rst_a", if_a.lcd_data, if_a.lcd_dcx, if_a.lcd_wrx,
            if_a.lcd_csx, busy_a, done_a, x_a, y_a);
    chk_rst("rst_b", if_b.lcd_data, if_b.lcd_dcx, if_b.lcd_wrx,
            if_b.lcd_csx, busy_b, done_b, x_b, y_b);
    nrst_a = 1'b1; nrst_bc = 1'b1;

    grab_hdr_a("a1");
    n = 0;
    while (if_a.lcd_wrx && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("a_hi_low_seen", if_a.lcd_wrx, 1'b0);
    nrst_a = 1'b0;
    @(negedge clk);
    chk_rst("midrst_a", if_a.lcd_data, if_a.lcd_dcx, if_a.lcd_wrx,
            if_a.lcd_csx, busy_a, done_a, x_a, y_a);
    nrst_a = 1'b1;
    grab_hdr_a("a2");
    nrst_a = 1'b0;

    run_frame(0, 3'b111);
    run_frame(0, 3'b000);
    run_frame(0, 3'b001);
    run_frame(0, 3'($urandom_range(0, 7)));
    run_frame(1, 3'b010);
    run_frame(1, 3'($urandom_range(0, 7)));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
